// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - EX-stage multiply/divide unit with HI/LO pair (optional MADD-class ops under MDU_MADD_EN)
module ex_muldiv_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDU_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Req,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDU_out
);

  // The latency counter is 5 bits wide, so latencies must fit in 1..31.
  if (MULT_CYCLES < 1 || MULT_CYCLES > 31) begin : g_bad_mult_cycles
    $error("ex_muldiv_unit: MULT_CYCLES must be in 1..31");
  end
  if (DIV_CYCLES < 1 || DIV_CYCLES > 31) begin : g_bad_div_cycles
    $error("ex_muldiv_unit: DIV_CYCLES must be in 1..31");
  end

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  localparam logic [4:0] MULT_N = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_N  = 5'(DIV_CYCLES);

  logic [4:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        is_mul_op, is_div_op, do_issue, do_mt, done;
  logic [63:0] mul_s, mul_u;
  logic [31:0] div_b, abs_a, abs_b, uq, ur, sq, sr, udq, udr;
`ifdef MDU_MADD_EN
  logic [63:0] acc;
`endif

  // Decode the incoming request; only an idle, unflushed unit accepts work.
  always_comb begin
    is_mul_op = (MDU_op == OP_MULT) || (MDU_op == OP_MULTU);
`ifdef MDU_MADD_EN
    is_mul_op = is_mul_op || (MDU_op == OP_MADD) || (MDU_op == OP_MADDU) ||
                (MDU_op == OP_MSUB) || (MDU_op == OP_MSUBU);
`endif
    is_div_op = (MDU_op == OP_DIV) || (MDU_op == OP_DIVU);
    do_issue  = Start && !Req && !Busy && (is_mul_op || is_div_op);
    do_mt     = !Start && !Req && !Busy && ((MDU_op == OP_MTHI) || (MDU_op == OP_MTLO));
    done      = (cnt_q == 5'd1);
  end

  // Result datapath, fed only from the latched operands. Signed divide works
  // on magnitudes and re-applies signs: quotient truncates toward zero and the
  // remainder follows the dividend. A zero divisor is replaced by 1 so the
  // dividers never see it; the result is discarded in that case anyway.
  always_comb begin
    mul_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    mul_u = {32'd0, a_q} * {32'd0, b_q};
    div_b = (b_q == 32'd0) ? 32'd1 : b_q;
    abs_a = a_q[31] ? -a_q : a_q;
    abs_b = div_b[31] ? -div_b : div_b;
    uq    = abs_a / abs_b;
    ur    = abs_a % abs_b;
    sq    = (a_q[31] ^ div_b[31]) ? -uq : uq;
    sr    = a_q[31] ? -ur : ur;
    udq   = a_q / div_b;
    udr   = a_q % div_b;
  end

`ifdef MDU_MADD_EN
  // Accumulate against HI/LO as they stand at the completion edge.
  always_comb begin
    case (op_q)
      OP_MADD:  acc = {hi_q, lo_q} + mul_s;
      OP_MADDU: acc = {hi_q, lo_q} + mul_u;
      OP_MSUB:  acc = {hi_q, lo_q} - mul_s;
      OP_MSUBU: acc = {hi_q, lo_q} - mul_u;
      default:  acc = {hi_q, lo_q};
    endcase
  end
`endif

  // Next-state: count down an in-flight op and retire it, else issue or move-to.
  always_comb begin
    cnt_d = cnt_q;
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (cnt_q != 5'd0) begin
      cnt_d = cnt_q - 5'd1;
      if (done) begin
        case (op_q)
          OP_MULT:  {hi_d, lo_d} = mul_s;
          OP_MULTU: {hi_d, lo_d} = mul_u;
          OP_DIV:   if (b_q != 32'd0) {hi_d, lo_d} = {sr, sq};
          OP_DIVU:  if (b_q != 32'd0) {hi_d, lo_d} = {udr, udq};
`ifdef MDU_MADD_EN
          OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: {hi_d, lo_d} = acc;
`endif
          default: ;
        endcase
      end
    end else if (do_issue) begin
      op_d  = MDU_op;
      a_d   = A;
      b_d   = B;
      cnt_d = is_div_op ? DIV_N : MULT_N;
    end else if (do_mt) begin
      if (MDU_op == OP_MTHI) hi_d = A;
      else                   lo_d = A;
    end
  end

  // State registers; reset clears everything at once, abandoning any op.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 5'd0;
      op_q  <= OP_NONE;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  // Outputs; MFHI/MFLO read HI/LO directly, stale while an op is in flight.
  always_comb begin
    Busy = (cnt_q != 5'd0);
    HI   = hi_q;
    LO   = lo_q;
    case (MDU_op)
      OP_MFHI: MDU_out = hi_q;
      OP_MFLO: MDU_out = lo_q;
      default: MDU_out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - scoreboard bench for ex_muldiv_unit
module tb_ex_muldiv_unit;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [3:0]  MDU_op;
  logic [31:0] A, B;
  logic        Req;
  logic        Busy;
  logic [31:0] HI, LO, MDU_out;

  int          n_checks = 0;
  int          n_fail = 0;
  int          illegal_starts = 0;
  int          illegal_exp = 0;
  logic [63:0] sb_q[$];
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  ex_muldiv_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDU_op(MDU_op), .A(A), .B(B),
    .Req(Req), .Busy(Busy), .HI(HI), .LO(LO), .MDU_out(MDU_out)
  );

  always #5 clk = ~clk;

  // Hazard-unit contract monitor: Start must never coincide with Busy.
  always @(negedge clk) if (reset && Start && Busy) illegal_starts++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] hi, input logic [31:0] lo);
    int ia = a;
    int ib = b;
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    case (op)
      4'd1: return longint'(ia) * longint'(ib);
      4'd2: return ua * ub;
      4'd3: if (b == 32'd0) return {hi, lo}; else return {32'(ia % ib), 32'(ia / ib)};
      4'd4: if (b == 32'd0) return {hi, lo}; else return {a % b, a / b};
      4'd9:  return {hi, lo} + 64'(longint'(ia) * longint'(ib));
      4'd10: return {hi, lo} + ua * ub;
      4'd11: return {hi, lo} - 64'(longint'(ia) * longint'(ib));
      4'd12: return {hi, lo} - ua * ub;
      default: return {hi, lo};
    endcase
  endfunction

  // req_at: 0 = Req with the issue, k>0 = Req during busy cycle k, <0 = never.
  // disturb: 1 = MTLO and new operands while busy, 2 = Start held while busy.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int exp_n, input int req_at, input int disturb);
    logic [63:0] e;
    int cyc;
    @(posedge clk); #1;
    Start = 1'b1; MDU_op = op; A = a; B = b; Req = (req_at == 0);
    if (exp_n > 0) begin
      e = model(op, a, b, hi_m, lo_m);
      sb_q.push_back(e);
      {hi_m, lo_m} = e;
    end
    @(posedge clk); #1;
    Start = 1'b0; MDU_op = 4'd0; A = $urandom; B = $urandom; Req = 1'b0;
    cyc = 0;
    while (Busy && cyc < 64) begin
      Req = (req_at == cyc + 1);
      if (disturb == 1) begin MDU_op = 4'd8; A = $urandom; end
      if (disturb == 2) begin Start = 1'b1; MDU_op = 4'd2; A = $urandom; B = $urandom; illegal_exp++; end
      @(posedge clk); #1;
      cyc++;
    end
    Start = 1'b0; Req = 1'b0; MDU_op = 4'd0;
    check({tag, " busy_cycles"}, 64'(cyc), 64'(exp_n));
    if (sb_q.size() > 0) check({tag, " hi_lo"}, {HI, LO}, sb_q.pop_front());
    else                 check({tag, " hi_lo_unchanged"}, {HI, LO}, {hi_m, lo_m});
  endtask

  task automatic move_to(input string tag, input logic [3:0] op, input logic [31:0] val);
    @(posedge clk); #1;
    MDU_op = op; A = val;
    @(posedge clk); #1;
    MDU_op = 4'd0;
    if (op == 4'd7) hi_m = val; else lo_m = val;
    check({tag, " hi_lo"}, {HI, LO}, {hi_m, lo_m});
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    reset = 1'b0; Start = 1'b0; MDU_op = 4'd5; A = 32'd0; B = 32'd0; Req = 1'b0;
    #1;
    check("reset hi_lo", {HI, LO}, 64'd0);
    check("reset busy", 64'(Busy), 64'd0);
    check("reset mfhi", 64'(MDU_out), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1; MDU_op = 4'd0;

    run_op("mult", 4'd1, 32'hFFFFFFFD, 32'd5, MC, -1, 0);
    check("mult const", {HI, LO}, 64'hFFFFFFFF_FFFFFFF1);
    run_op("multu", 4'd2, 32'hFFFFFFFD, 32'd5, MC, -1, 0);
    check("multu const", {HI, LO}, 64'h00000004_FFFFFFF1);
    run_op("div", 4'd3, 32'hFFFFFFF9, 32'd2, DC, -1, 0);
    check("div const", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
    run_op("divu", 4'd4, 32'd7, 32'd2, DC, -1, 0);
    check("divu const", {HI, LO}, 64'h00000001_00000003);
    run_op("div0", 4'd3, 32'd99, 32'd0, DC, -1, 0);
    run_op("start_req", 4'd1, 32'd6, 32'd7, 0, 0, 0);
    run_op("req_inflight", 4'd1, 32'd6, 32'd7, MC, 3, 0);

    move_to("mthi", 4'd7, 32'hDEADBEEF);
    MDU_op = 4'd5; #1;
    check("mfhi", 64'(MDU_out), 64'hDEADBEEF);
    move_to("mtlo", 4'd8, 32'h0BADF00D);
    MDU_op = 4'd6; #1;
    check("mflo", 64'(MDU_out), 64'h0BADF00D);
    MDU_op = 4'd0; #1;
    check("mdu_out none", 64'(MDU_out), 64'd0);

    run_op("mtlo_busy", 4'd2, 32'h12345678, 32'h9ABCDEF0, MC, -1, 1);
    run_op("start_busy", 4'd1, 32'h80000000, 32'h00000003, MC, -1, 2);
    check("illegal start monitor", 64'(illegal_starts), 64'(illegal_exp));

    for (int i = 0; i < 8; i++) begin
      rop = 4'(1 + (i % 4));
      ra  = $urandom;
      rb  = (i < 4) ? $urandom : $urandom_range(1, 300);
      if (rb == 32'hFFFFFFFF) rb = 32'd3;
      run_op("random", rop, ra, rb, (rop > 4'd2) ? DC : MC, -1, 0);
    end

    move_to("madd prep hi", 4'd7, 32'd0);
    move_to("madd prep lo", 4'd8, 32'hFFFFFFFF);
`ifdef MDU_MADD_EN
    run_op("maddu", 4'd10, 32'd1, 32'd1, MC, -1, 0);
    check("maddu const", {HI, LO}, 64'h00000001_00000000);
    run_op("msub", 4'd11, 32'hFFFFFFFF, 32'd2, MC, -1, 0);
`else
    run_op("maddu_off", 4'd10, 32'd1, 32'd1, 0, -1, 0);
    check("maddu_off const", {HI, LO}, 64'h00000000_FFFFFFFF);
`endif

    move_to("rst prep", 4'd7, 32'h00001234);
    @(posedge clk); #1;
    Start = 1'b1; MDU_op = 4'd3; A = 32'd100; B = 32'd7;
    @(posedge clk); #1;
    Start = 1'b0; MDU_op = 4'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("async reset hi_lo", {HI, LO}, 64'd0);
    check("async reset busy", 64'(Busy), 64'd0);
    #2 reset = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("post reset hi_lo", {HI, LO}, 64'd0);
    check("post reset busy", 64'(Busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
